riscv_fetch_stage: RTL
======================

# riscv_fetch_stage

Instruction-fetch stage of the RISC-V Lite core: owns the program counter, issues one instruction-memory request at a time and presents the fetched word to the decode stage.

- The IF/ID pipeline register is built into the block.
- The block honours the hazard-unit stall and the execute-stage redirect (branch/jump).
- Only one memory request is outstanding at any time, so the memory protocol stays trivial; sustained throughput is one instruction every 2 cycles.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded by reset.
- NOP_INSTR, 32'h0000_0013, word presented on if_instr during bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- imem_req  out  1  request valid, registered.
- imem_addr  out  32  request address; equals the internal pc, bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle. Meaningful only while imem_req=1.
- imem_rvalid  in  1  response valid. Arrives at least 1 cycle after imem_gnt.
- imem_rdata  in  32  instruction word. Qualified by imem_rvalid.
- stall  in  1  decode cannot accept; if_* must hold.
- redirect_valid  in  1  redirect request from execute; flushes the fetch pipeline.
- redirect_pc  in  32  redirect target. Bits [1:0] are ignored (forced to 0).
- if_valid  out  1  IF/ID holds a real instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction, or NOP_INSTR when if_valid=0.

## Operation
States: REQ, WAIT, HOLD. Internal registers: pc, squash flag, hold buffer (32 bit).

Reset (rstn=0 at an edge):
- State goes to REQ, pc=RESET_PC, squash=0.
- imem_req=0 during the reset cycle. imem_addr=RESET_PC.
- if_valid=0, if_pc=0, if_instr=NOP_INSTR.
- Reset mid-transaction abandons any outstanding response. The memory must also be reset.

State behaviour:
- **REQ:** imem_req=1. On imem_gnt, go to WAIT.
- **WAIT:** imem_req=0. On imem_rvalid:
  - If squash=1: discard the response, clear squash, go to REQ.
  - Else if stall=0: load IF/ID with if_valid=1, if_pc=pc, if_instr=imem_rdata. Set pc=pc+4 and go to REQ.
  - Else (stall=1): store imem_rdata in the hold buffer and go to HOLD.
- **HOLD:** when stall=0, load IF/ID from the hold buffer with if_pc=pc. Set pc=pc+4 and go to REQ.

IF/ID update rules:
- stall=1: all if_* hold their values.
- stall=0 and no instruction delivered this cycle: if_valid<=0, if_instr<=NOP_INSTR (bubble); if_pc holds.

Redirect (priority over stall and over all state actions):
- Set pc<=redirect_pc & ~3, if_valid<=0, if_instr<=NOP_INSTR. The hold buffer is dropped.
- Next state depends on the current state:
  - REQ without imem_gnt: stay in REQ (the next request uses the new pc).
  - REQ with imem_gnt in the same cycle: go to WAIT with squash=1.
  - WAIT without imem_rvalid: stay in WAIT with squash=1.
  - WAIT with imem_rvalid: the response is discarded, go to REQ.
  - HOLD: go to REQ.
- A second redirect while squash=1 only updates pc.

Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset release to first request: imem_req=1 in the first cycle after rstn goes high.
- imem_gnt at edge N, imem_rvalid at edge N+1: if_valid=1 after edge N+1, and the next imem_req=1 is also visible after edge N+1. This gives 2 cycles per instruction.
- Redirect at edge N (no squash pending): imem_req=1 with imem_addr=new target after edge N. First redirected instruction appears on if_* no earlier than 2 edges later.
- Stall asserted for k cycles after a response: the word waits in HOLD. It reaches IF/ID on the first edge with stall=0. No request is issued during HOLD.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- **Reset/sequential fetch:** zero-wait memory returning 32'h00A00093, 32'h00100113 → imem_addr 0x400000 then 0x400004; if_pc/if_instr match; if_valid pulses every second cycle.
- **Stall during WAIT:** stall=1 for 3 cycles around the rvalid of 0x400004 → word captured in HOLD, no imem_req, if_* frozen; word delivered the first cycle after stall drops.
- **Redirect while WAIT:** redirect to 0x400100 one cycle before the rvalid for 0x400008 → that response is discarded; next request address is 0x400100; if_valid=0 until the 0x400100 word arrives.
- **Redirect coincident with gnt:** redirect_valid and imem_gnt in the same cycle, redirect_pc=0x400203 → squash set; the old response is dropped; next imem_addr=0x400200.
- **Redirect during stall (HOLD):** redirect wins → hold buffer dropped, if_valid=0, fetch restarts at the target.
- **Wrap and reset mid-operation:** redirect to 0xFFFFFFFC → next address 0x00000000. Then rstn=0 while in WAIT → all outputs return to their reset values and pc=0x400000.

Source files
------------

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: owns the PC, keeps at most one imem request outstanding, and feeds the IF/ID register.
// Fetches one instruction every 2 cycles; on stall a returned word parks in a hold buffer and no new request is issued.
module riscv_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic        squash, squash_nxt;
   logic [31:0] pc;
   logic [31:0] hold_buf;
   logic        gnt_ok;
   logic        deliver;
   logic        capture;
   logic [31:0] deliver_word;

   // imem_req is low for one cycle after reset, so a grant only counts while it is high
   assign gnt_ok    = imem_req & imem_gnt;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= S_REQ;
         squash <= 1'b0;
      end else begin
         state  <= state_nxt;
         squash <= squash_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      squash_nxt = squash;
      case (state)
         S_REQ: begin
            if (gnt_ok) begin
               state_nxt  = S_WAIT;
               squash_nxt = redirect_valid;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               squash_nxt = 1'b0;
               if (redirect_valid || squash || !stall) state_nxt = S_REQ;
               else                                    state_nxt = S_HOLD;
            end else if (redirect_valid) begin
               squash_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || !stall) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
   end

   always_comb begin
      deliver      = 1'b0;
      capture      = 1'b0;
      deliver_word = hold_buf;
      if (!redirect_valid && state == S_WAIT && imem_rvalid && !squash) begin
         if (stall) begin
            capture = 1'b1;
         end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
         end
      end else if (!redirect_valid && !stall && state == S_HOLD) begin
         deliver = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc       <= RESET_PC;
         imem_req <= 1'b0;
         hold_buf <= 32'h0;
         if_valid <= 1'b0;
         if_pc    <= 32'h0;
         if_instr <= NOP_INSTR;
      end else begin
         imem_req <= (state_nxt == S_REQ);
         if (capture) hold_buf <= imem_rdata;
         if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
         end else if (deliver) begin
            pc       <= pc + 32'd4;
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= deliver_word;
         end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
         end
      end
   end

endmodule
